// File: rtl/wash_cycle_sequencer.sv
// Washer programme sequencer: FILL/RINSE/DRAIN passes, then SPIN and ALERT.
// Optional accelerated countdown when WM_ACCEL_EN is defined (adds port accel).
module wash_cycle_sequencer #(
  parameter int TW           = 16,
  parameter int REPS_W       = 3,
  parameter int FILL_TIMEOUT = 1200,
  parameter int RINSE_TICKS  = 6000,
  parameter int DRAIN_TICKS  = 300,
  parameter int SPIN_TICKS   = 3000,
  parameter int ALERT_TICKS  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              water_full,
`ifdef WM_ACCEL_EN
  input  logic              accel,
`endif
  input  logic [REPS_W-1:0] reps,
  output logic [6:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [TW-1:0]     remaining,
  output logic [REPS_W-1:0] pass_cnt
);

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_FILL  = 7'b0000010,
    S_RINSE = 7'b0000100,
    S_DRAIN = 7'b0001000,
    S_SPIN  = 7'b0010000,
    S_ALERT = 7'b0100000,
    S_FAULT = 7'b1000000
  } state_t;

  localparam logic [TW-1:0] L_FILL  = TW'(FILL_TIMEOUT);
  localparam logic [TW-1:0] L_RINSE = TW'(RINSE_TICKS);
  localparam logic [TW-1:0] L_DRAIN = TW'(DRAIN_TICKS);
  localparam logic [TW-1:0] L_SPIN  = TW'(SPIN_TICKS);
  localparam logic [TW-1:0] L_ALERT = TW'(ALERT_TICKS);
  localparam logic [TW-1:0] ONE     = TW'(1);

  state_t              state;
  logic [REPS_W-1:0]   reps_lat;
  logic [REPS_W-1:0]   reps_eff;
  logic [TW-1:0]       dec;
  logic                expire;
  logic                count;

  assign phase = state;

  // Zero passes requested still runs a single pass.
  assign reps_eff = (reps == '0) ? REPS_W'(1) : reps;

`ifdef WM_ACCEL_EN
  localparam logic [TW-1:0] ACC = TW'(10);
  assign dec    = accel ? ACC : ONE;
  assign expire = tick & ~pause & (remaining <= dec);
`else
  assign dec    = ONE;
  assign expire = tick & ~pause & (remaining == ONE);
`endif

  assign count = tick & ~pause & (remaining > dec);

  // Programme FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      pass_cnt  <= '0;
      reps_lat  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        fault     <= 1'b0;
        remaining <= '0;
        pass_cnt  <= '0;
      end else if (!pause) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_FILL;
              busy      <= 1'b1;
              reps_lat  <= reps_eff;
              pass_cnt  <= REPS_W'(1);
              remaining <= L_FILL;
            end
          end
          S_FILL: begin
            if (water_full) begin
              state     <= S_RINSE;
              remaining <= L_RINSE;
            end else if (expire) begin
              state     <= S_FAULT;
              busy      <= 1'b0;
              fault     <= 1'b1;
              remaining <= '0;
            end else if (count) begin
              remaining <= remaining - dec;
            end
          end
          S_RINSE: begin
            if (expire) begin
              state     <= S_DRAIN;
              remaining <= L_DRAIN;
            end else if (count) begin
              remaining <= remaining - dec;
            end
          end
          S_DRAIN: begin
            if (expire) begin
              if (pass_cnt < reps_lat) begin
                state     <= S_FILL;
                pass_cnt  <= pass_cnt + REPS_W'(1);
                remaining <= L_FILL;
              end else begin
                state     <= S_SPIN;
                remaining <= L_SPIN;
              end
            end else if (count) begin
              remaining <= remaining - dec;
            end
          end
          S_SPIN: begin
            if (expire) begin
              state     <= S_ALERT;
              remaining <= L_ALERT;
            end else if (count) begin
              remaining <= remaining - dec;
            end
          end
          S_ALERT: begin
            if (expire) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              remaining <= '0;
              pass_cnt  <= '0;
            end else if (count) begin
              remaining <= remaining - dec;
            end
          end
          S_FAULT: begin
            if (start) begin
              state    <= S_IDLE;
              fault    <= 1'b0;
              pass_cnt <= '0;
            end
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            fault     <= 1'b0;
            remaining <= '0;
            pass_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Randomized and directed bench for wash_cycle_sequencer.
// Reference model tracks elapsed ticks per phase against a duration table.
module tb_wash_cycle_sequencer;

  localparam int FT = 5;
  localparam int RT = 4;
  localparam int DT = 2;
  localparam int ST = 3;
  localparam int AT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, abort, pause, water_full;
  logic        accel;
  logic [2:0]  reps;
  logic [6:0]  phase;
  logic        busy, done, fault;
  logic [15:0] remaining;
  logic [2:0]  pass_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 IDLE 1 FILL 2 RINSE 3 DRAIN 4 SPIN 5 ALERT 6 FAULT
  int m_ph, m_el, m_pass, m_reps;
  bit m_done;

  always #5 clk = ~clk;

  wash_cycle_sequencer #(
    .TW(16), .REPS_W(3), .FILL_TIMEOUT(FT), .RINSE_TICKS(RT),
    .DRAIN_TICKS(DT), .SPIN_TICKS(ST), .ALERT_TICKS(AT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .abort(abort), .pause(pause), .water_full(water_full),
`ifdef WM_ACCEL_EN
    .accel(accel),
`endif
    .reps(reps), .phase(phase), .busy(busy), .done(done),
    .fault(fault), .remaining(remaining), .pass_cnt(pass_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      1: return FT;
      2: return RT;
      3: return DT;
      4: return ST;
      5: return AT;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_run(input int ph);
    return ph >= 1 && ph <= 5;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_el = 0; m_pass = 0; m_reps = 0; m_done = 0;
  endtask

  task automatic m_enter(input int ph);
    m_ph = ph; m_el = 0;
  endtask

  task automatic m_next(input bit t, s, a, p, w, input int r, input bit ac);
    int left, stepv;
    bit ex;
    m_done = 0;
    if (a && m_ph != 0) begin
      m_ph = 0; m_el = 0; m_pass = 0;
      return;
    end
    if (p) return;
    stepv = ac ? 10 : 1;
    left  = dur(m_ph) - m_el;
    ex    = t && (left <= stepv);
    case (m_ph)
      0: if (s) begin
           m_enter(1); m_pass = 1; m_reps = (r == 0) ? 1 : r;
         end
      1: if (w) m_enter(2);
         else if (ex) m_enter(6);
         else if (t) m_el += stepv;
      2: if (ex) m_enter(3); else if (t) m_el += stepv;
      3: if (ex) begin
           if (m_pass < m_reps) begin m_pass++; m_enter(1); end
           else m_enter(4);
         end else if (t) m_el += stepv;
      4: if (ex) m_enter(5); else if (t) m_el += stepv;
      5: if (ex) begin
           m_enter(0); m_done = 1; m_pass = 0;
         end else if (t) m_el += stepv;
      6: if (s) begin m_enter(0); m_pass = 0; end
      default: m_enter(0);
    endcase
  endtask

  task automatic check_all();
    chk("phase", phase, 32'(1) << m_ph);
    chk("busy", busy, in_run(m_ph));
    chk("fault", fault, m_ph == 6);
    chk("done", done, m_done);
    chk("remaining", remaining,
        in_run(m_ph) ? dur(m_ph) - m_el : 0);
    chk("pass_cnt", pass_cnt, m_pass);
  endtask

  task automatic step(input bit t, s, a, p, w, input int r, input bit ac);
    bit ace;
`ifdef WM_ACCEL_EN
    ace = ac;
`else
    ace = 1'b0;
`endif
    tick = t; start = s; abort = a; pause = p;
    water_full = w; reps = 3'(r); accel = ace;
    m_next(t, s, a, p, w, r, ace);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int rins, dn, pmax;
    rst = 1'b1;
    tick = 0; start = 0; abort = 0; pause = 0;
    water_full = 0; reps = 0; accel = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // two passes, water_full one cycle after FILL entry
    step(1, 1, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0, 2, 0);
    rins = 0; dn = 0; pmax = 0;
    for (int k = 0; k < 40 && m_ph != 0; k++) begin
      step(1, 0, 0, 0, 1, 2, 0);
      if (phase == 7'b0000100) rins++;
      if (done) dn++;
      if (int'(pass_cnt) > pmax) pmax = pass_cnt;
    end
    chk("t1_rinse_cycles", rins, 2 * RT);
    chk("t1_done_pulses", dn, 1);
    chk("t1_pass_max", pmax, 2);
    step(1, 0, 0, 0, 0, 2, 0);
    chk("t1_idle_after", phase, 7'b0000001);

    // fill timeout
    step(1, 1, 0, 0, 0, 1, 0);
    repeat (FT) step(1, 0, 0, 0, 0, 1, 0);
    chk("t2_fault", fault, 1);
    chk("t2_rem", remaining, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("t2_ack", phase, 7'b0000001);

    // pause in RINSE
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    repeat (10) step(1, 0, 0, 1, 0, 1, 0);
    chk("t3_hold", remaining, 3);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t3_still_rinse", phase, 7'b0000100);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t3_drain", phase, 7'b0001000);
    for (int k = 0; k < 30 && m_ph != 0; k++) step(1, 0, 0, 0, 1, 1, 0);

    // reps=0 one pass, abort in SPIN
    pmax = 0;
    step(1, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 30 && m_ph != 4; k++) begin
      step(1, 0, 0, 0, 1, 0, 0);
      if (int'(pass_cnt) > pmax) pmax = pass_cnt;
    end
    chk("t4_reach_spin", phase, 7'b0010000);
    chk("t4_one_pass", pmax, 1);
    step(0, 0, 1, 0, 1, 0, 0);
    chk("t4_abort_ph", phase, 7'b0000001);
    chk("t4_abort_done", done, 0);

    // async reset mid-DRAIN
    step(1, 1, 0, 0, 1, 3, 0);
    for (int k = 0; k < 30 && m_ph != 3; k++) step(1, 0, 0, 0, 1, 3, 0);
    chk("t5_in_drain", phase, 7'b0001000);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7),
           $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
